// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader, plus load status.
interface program_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, cpu_reset, load_done, load_error, byte_count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, cpu_reset, load_done, load_error, byte_count
  );
endinterface

// File: rtl/program_loader.sv
// Receives a framed byte stream (length, payload, checksum), writes the payload into program
// memory and keeps the CPU in reset until a frame with a good checksum has been loaded.
module program_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input logic             i_clk,
  input logic             i_reset,
  program_loader_if.slave io_bus
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCsum, StDone, StError
  } state_e;

  state_e      r_state;
  logic [15:0] r_len;
  logic [7:0]  r_sum;
  logic        r_in_ready;
  logic        r_mem_we;
  logic [31:0] r_mem_waddr;
  logic [7:0]  r_mem_wdata;
  logic        r_cpu_reset;
  logic        r_load_done;
  logic        r_load_error;
  logic [15:0] r_byte_count;

  logic        w_accept;
  logic [15:0] w_len_full;
  logic [7:0]  w_sum_next;

  assign w_accept   = io_bus.in_valid & r_in_ready;
  assign w_len_full = {r_len[15:8], io_bus.in_data};
  assign w_sum_next = r_sum + io_bus.in_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_len        <= 16'd0;
      r_sum        <= 8'd0;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= 32'd0;
      r_mem_wdata  <= 8'd0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_byte_count <= 16'd0;
    end else begin
      r_mem_we <= 1'b0;
      unique case (r_state)
        StIdle, StDone, StError: begin
          if (io_bus.start) begin
            r_state      <= StLenHi;
            r_in_ready   <= 1'b1;
            r_sum        <= 8'd0;
            r_byte_count <= 16'd0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_cpu_reset  <= 1'b1;
          end
        end
        StLenHi: begin
          if (w_accept) begin
            r_len[15:8] <= io_bus.in_data;
            r_sum       <= w_sum_next;
            r_state     <= StLenLo;
          end
        end
        StLenLo: begin
          if (w_accept) begin
            r_len <= w_len_full;
            r_sum <= w_sum_next;
            if (w_len_full == 16'd0) begin
              r_state <= StCsum;
            end else if (32'(w_len_full) > DEPTH) begin
              // Oversized frame: stop accepting, the sender must restart with start
              r_state      <= StError;
              r_in_ready   <= 1'b0;
              r_load_error <= 1'b1;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_accept) begin
            r_mem_we     <= 1'b1;
            r_mem_waddr  <= BASE_ADDR + 32'(r_byte_count);
            r_mem_wdata  <= io_bus.in_data;
            r_byte_count <= r_byte_count + 16'd1;
            r_sum        <= w_sum_next;
            if (r_byte_count + 16'd1 == r_len) r_state <= StCsum;
          end
        end
        StCsum: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            // Checksum byte makes the running sum wrap to zero on a good frame
            if (w_sum_next == 8'd0) begin
              r_state     <= StDone;
              r_load_done <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state      <= StError;
              r_load_error <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_waddr  = r_mem_waddr;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.cpu_reset  = r_cpu_reset;
  assign io_bus.load_done  = r_load_done;
  assign io_bus.load_error = r_load_error;
  assign io_bus.byte_count = r_byte_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level model.
module tb_program_loader;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'd0;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic [39:0] wlog[$];

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  // Write monitor: every mem_we pulse is exactly one cycle wide
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wlog.push_back({bus.mem_waddr, bus.mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers bytes with random idle gaps; returns how many were accepted before the bound expired.
  task automatic send(input bq_t q, input int gap_pct, input int max_cycles, output int sent);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < q.size() && cyc < max_cycles) begin
      acc = 1'b0;
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = q[idx];
        acc          = bus.in_ready;
      end
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    sent = idx;
  endtask

  task automatic build(input int len, input bit good, output bq_t f);
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] l16;
    l16 = 16'(len);
    f = {};
    f.push_back(l16[15:8]);
    f.push_back(l16[7:0]);
    if (len > int'(DEPTH)) return;
    s = l16[15:8] + l16[7:0];
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      s = s + b;
    end
    b = 8'd0 - s;
    if (!good) b = b + 8'($urandom_range(1, 255));
    f.push_back(b);
  endtask

  // Frame-level model: length from the first two bytes, sum of all bytes must wrap to zero.
  task automatic run_frame(input string tag, input bq_t f, input int gap, input bit noise);
    int         len;
    int         sent;
    int         exp_writes;
    logic [7:0] s;
    bit         len_err;
    bit         good;
    len     = int'({f[0], f[1]});
    len_err = len > int'(DEPTH);
    wlog.delete();
    if (noise) begin
      repeat (5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check({tag, "_noise_writes"}, wlog.size(), 0);
      check({tag, "_noise_ready"}, 32'(bus.in_ready), 0);
    end
    pulse_start();
    send(f, gap, 8 * f.size() + 64, sent);
    repeat (2) @(negedge clk);
    s = 8'd0;
    foreach (f[i]) s = s + f[i];
    good       = !len_err && (s == 8'd0);
    exp_writes = len_err ? 0 : len;
    check({tag, "_accepted"}, sent, f.size());
    check({tag, "_writes"}, wlog.size(), exp_writes);
    for (int i = 0; i < wlog.size() && i < exp_writes; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wlog[i][39:8], BASE + 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wlog[i][7:0]), 32'(f[2 + i]));
    end
    if (exp_writes > 0) begin
      check({tag, "_hold_addr"}, bus.mem_waddr, BASE + 32'(exp_writes - 1));
      check({tag, "_hold_data"}, 32'(bus.mem_wdata), 32'(f[exp_writes + 1]));
    end
    check({tag, "_done"}, 32'(bus.load_done), 32'(good));
    check({tag, "_error"}, 32'(bus.load_error), 32'(!good));
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!good));
    check({tag, "_count"}, 32'(bus.byte_count), 32'(exp_writes));
    check({tag, "_ready"}, 32'(bus.in_ready), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_we"}, 32'(bus.mem_we), 0);
    check({tag, "_waddr"}, bus.mem_waddr, 0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
    check({tag, "_done"}, 32'(bus.load_done), 0);
    check({tag, "_error"}, 32'(bus.load_error), 0);
    check({tag, "_count"}, 32'(bus.byte_count), 0);
  endtask

  initial begin
    bq_t f;
    int  sent;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);

    f = '{8'h00, 8'h05, 8'h55, 8'h89, 8'hE5, 8'h5D, 8'hC3, 8'h18};
    run_frame("t1_good", f, 0, 1'b0);
    f = '{8'h00, 8'h05, 8'h55, 8'h89, 8'hE5, 8'h5D, 8'hC3, 8'h19};
    run_frame("t2_badsum", f, 0, 1'b0);
    f = '{8'h01, 8'h01};
    run_frame("t3_toolong", f, 0, 1'b0);
    f = '{8'h00, 8'h00, 8'h00};
    run_frame("t4_empty", f, 0, 1'b0);
    build(256, 1'b1, f);
    run_frame("t4_full", f, 0, 1'b0);
    f = '{8'h00, 8'h05, 8'h55, 8'h89, 8'hE5, 8'h5D, 8'hC3, 8'h18};
    run_frame("t5_gaps", f, 40, 1'b1);

    for (int k = 0; k < 10; k++) begin
      build(int'($urandom_range(1, 24)), 1'($urandom_range(1)), f);
      run_frame($sformatf("rnd%0d", k), f, 30, 1'($urandom_range(1)));
    end
    build(int'($urandom_range(257, 65535)), 1'b1, f);
    run_frame("rnd_toolong", f, 30, 1'b0);

    // Reset in the middle of a payload
    wlog.delete();
    pulse_start();
    f = '{8'h00, 8'h05, 8'h55, 8'h89};
    send(f, 0, 64, sent);
    check("t6_sent", sent, 4);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t6_rst");
    reset = 1'b0;
    repeat (3) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hE5;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t6_writes", wlog.size(), 2);
    check("t6_ready", 32'(bus.in_ready), 0);
    check("t6_cpu_reset", 32'(bus.cpu_reset), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
